// File: rtl/tile_conv2d_mac.sv
// ============================================================================
// tile_conv2d_mac: 4-stage WIN_SIZE x WIN_SIZE convolution MAC with bias, rounding
// shift and saturation. Optional macro CONV_RELU_EN clamps negative results to 0.
// Rev 1.0
// ============================================================================
`default_nettype none

module tile_conv2d_mac #(
  parameter int DATA_W   = 8,
  parameter int COEF_W   = 8,
  parameter int WIN_SIZE = 3,
  parameter int OUT_W    = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          coef_valid_i,
  input  logic [COEF_W-1:0]                             coef_data_i,
  input  logic                                          coef_clear_i,
  output logic                                          coef_ready_o,
  input  logic                                          win_valid_i,
  input  logic [WIN_SIZE-1:0][WIN_SIZE-1:0][DATA_W-1:0] window_i,
  input  logic [15:0]                                   cfg_bias_i,
  input  logic [4:0]                                    cfg_shift_i,
  output logic                                          out_valid_o,
  output logic [OUT_W-1:0]                              out_pixel_o,
  output logic [15:0]                                   drop_cnt_o
);

  localparam int K      = WIN_SIZE * WIN_SIZE;
  localparam int IDX_W  = (K > 1) ? $clog2(K) : 1;
  localparam int ACC_W  = DATA_W + COEF_W + 2 + $clog2(K);
  localparam int PROD_W = DATA_W + 1 + COEF_W;
  localparam int ROW_W  = PROD_W + $clog2(WIN_SIZE + 1);
  // Wide enough that a rounding term of 2^30 can never wrap
  localparam int RND_W  = ACC_W + 32;
  localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'((64'd1 << (OUT_W - 1)) - 64'd1);
  localparam logic signed [RND_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [K-1:0][COEF_W-1:0] coef_q, coef_d;
  logic [15:0]              drop_q, drop_d;
  logic                     w_accept;

  assign w_accept = win_valid_i && (state_q == RUN) && !coef_clear_i;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    coef_d  = coef_q;
    unique case (state_q)
      LOAD: begin
        if (coef_clear_i) begin
          idx_d = '0;
        end else if (coef_valid_i) begin
          coef_d[idx_q] = coef_data_i;
          if (idx_q == IDX_W'(K - 1)) begin
            state_d = RUN;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      RUN: begin
        if (coef_clear_i) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    if (win_valid_i && !w_accept && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      idx_q   <= '0;
      coef_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      coef_q  <= coef_d;
      drop_q  <= drop_d;
    end
  end

  // S1 operands: pixel zero-extended, coefficient sign-extended
  logic [K-1:0][PROD_W-1:0] w_prod;
  for (genvar k = 0; k < K; k++) begin : g_prod
    logic signed [PROD_W-1:0] w_pix;
    logic signed [PROD_W-1:0] w_coef;
    assign w_pix     = PROD_W'(window_i[k / WIN_SIZE][k % WIN_SIZE]);
    assign w_coef    = {{(PROD_W - COEF_W){coef_q[k][COEF_W-1]}}, coef_q[k]};
    assign w_prod[k] = w_pix * w_coef;
  end

  logic                           s1_valid_q, s2_valid_q, s3_valid_q, out_valid_q;
  logic [K-1:0][PROD_W-1:0]       s1_prod_q;
  logic [WIN_SIZE-1:0][ROW_W-1:0] s2_row_q;
  logic signed [ACC_W-1:0]        s3_acc_q;
  logic [15:0]                    s1_bias_q, s2_bias_q;
  logic [4:0]                     s1_shift_q, s2_shift_q, s3_shift_q;
  logic [OUT_W-1:0]               out_pixel_q;

  logic [WIN_SIZE-1:0][ROW_W-1:0] w_row;
  always_comb begin
    w_row = '0;
    for (int r = 0; r < WIN_SIZE; r++) begin
      for (int c = 0; c < WIN_SIZE; c++) begin
        w_row[r] = w_row[r] + {{(ROW_W - PROD_W){s1_prod_q[r*WIN_SIZE+c][PROD_W-1]}},
                               s1_prod_q[r*WIN_SIZE+c]};
      end
    end
  end

  logic signed [ACC_W-1:0] w_total;
  always_comb begin
    w_total = {{(ACC_W - 16){s2_bias_q[15]}}, s2_bias_q};
    for (int r = 0; r < WIN_SIZE; r++) begin
      w_total = w_total + {{(ACC_W - ROW_W){s2_row_q[r][ROW_W-1]}}, s2_row_q[r]};
    end
  end

  logic signed [RND_W-1:0] w_rnd, w_shr;
  logic [OUT_W-1:0]        w_sat, w_out;
  always_comb begin
    w_rnd = {{(RND_W - ACC_W){s3_acc_q[ACC_W-1]}}, s3_acc_q};
    if (s3_shift_q != 5'd0) begin
      w_rnd = w_rnd + (RND_W'(1) << (s3_shift_q - 5'd1));
    end
    w_shr = w_rnd >>> s3_shift_q;
    if (w_shr > SAT_MAX) begin
      w_sat = SAT_MAX[OUT_W-1:0];
    end else if (w_shr < SAT_MIN) begin
      w_sat = SAT_MIN[OUT_W-1:0];
    end else begin
      w_sat = w_shr[OUT_W-1:0];
    end
`ifdef CONV_RELU_EN
    w_out = w_sat[OUT_W-1] ? '0 : w_sat;
`else
    w_out = w_sat;
`endif
  end

  // Bias and shift ride along with each window so config changes affect only later windows
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      s1_prod_q   <= '0;
      s2_row_q    <= '0;
      s3_acc_q    <= '0;
      s1_bias_q   <= '0;
      s2_bias_q   <= '0;
      s1_shift_q  <= '0;
      s2_shift_q  <= '0;
      s3_shift_q  <= '0;
      out_pixel_q <= '0;
    end else begin
      s1_valid_q  <= w_accept;
      s2_valid_q  <= s1_valid_q;
      s3_valid_q  <= s2_valid_q;
      out_valid_q <= s3_valid_q;
      if (w_accept) begin
        s1_prod_q  <= w_prod;
        s1_bias_q  <= cfg_bias_i;
        s1_shift_q <= cfg_shift_i;
      end
      if (s1_valid_q) begin
        s2_row_q   <= w_row;
        s2_bias_q  <= s1_bias_q;
        s2_shift_q <= s1_shift_q;
      end
      if (s2_valid_q) begin
        s3_acc_q   <= w_total;
        s3_shift_q <= s2_shift_q;
      end
      if (s3_valid_q) begin
        out_pixel_q <= w_out;
      end
    end
  end

  assign coef_ready_o = (state_q == RUN);
  assign out_valid_o  = out_valid_q;
  assign out_pixel_o  = out_pixel_q;
  assign drop_cnt_o   = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_tile_conv2d_mac.sv
// ============================================================================
// tb_tile_conv2d_mac: directed vector table plus multi-cycle sequences for tile_conv2d_mac.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tile_conv2d_mac;

  localparam int K = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             coef_valid;
  logic [7:0]       coef_data;
  logic             coef_clear;
  logic             coef_ready;
  logic             win_valid;
  logic [2:0][2:0][7:0] window;
  logic [15:0]      cfg_bias;
  logic [4:0]       cfg_shift;
  logic             out_valid;
  logic [7:0]       out_pixel;
  logic [15:0]      drop_cnt;

  tile_conv2d_mac dut (
    .clk          (clk),
    .rst          (rst),
    .coef_valid_i (coef_valid),
    .coef_data_i  (coef_data),
    .coef_clear_i (coef_clear),
    .coef_ready_o (coef_ready),
    .win_valid_i  (win_valid),
    .window_i     (window),
    .cfg_bias_i   (cfg_bias),
    .cfg_shift_i  (cfg_shift),
    .out_valid_o  (out_valid),
    .out_pixel_o  (out_pixel),
    .drop_cnt_o   (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string             name;
    logic [K-1:0][7:0] coef;
    logic [K-1:0][7:0] pix;
    logic [15:0]       bias;
    logic [4:0]        shift;
    int                exp_val;
  } vec_t;

  vec_t              vecs[13];
  int                checks   = 0;
  int                failures = 0;
  logic [K-1:0][7:0] pv;
  int                lat, val, drop0;
  logic              seen;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int relu(input int v);
`ifdef CONV_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic load_kernel(input logic [K-1:0][7:0] c);
    @(negedge clk);
    coef_clear = 1'b1;
    for (int k = 0; k < K; k++) begin
      @(negedge clk);
      coef_clear = 1'b0;
      coef_valid = 1'b1;
      coef_data  = c[k];
    end
    @(negedge clk);
    coef_valid = 1'b0;
  endtask

  // Drives one window, then watches up to 8 cycles for the first result
  task automatic run_window(input logic [K-1:0][7:0] p, input logic [15:0] b,
                            input logic [4:0] s, output int l, output int v);
    @(negedge clk);
    window    = p;
    cfg_bias  = b;
    cfg_shift = s;
    win_valid = 1'b1;
    l = 0;
    v = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      win_valid = 1'b0;
      if (out_valid && l == 0) begin
        l = k;
        v = int'($signed(out_pixel));
      end
    end
  endtask

  initial begin
    vecs[0]  = '{"ones_x10",     {K{8'd1}},   {K{8'd10}},  16'd0,      5'd0,  90};
    vecs[1]  = '{"bias_neg100",  {K{8'd1}},   {K{8'd10}},  -16'sd100,  5'd0,  -10};
    vecs[2]  = '{"sat_pos",      {K{8'd127}}, {K{8'd255}}, 16'd0,      5'd0,  127};
    vecs[3]  = '{"sat_neg",      {K{8'h80}},  {K{8'd255}}, 16'd0,      5'd0,  -128};
    vecs[4]  = '{"sum45_sh2",    {K{8'd1}},
                 {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},  16'd0, 5'd2, 11};
    vecs[5]  = '{"sum46_sh2",    {K{8'd1}},
                 {8'd10, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 16'd0, 5'd2, 12};
    vecs[6]  = '{"neg45_sh2",    {K{8'hFF}},
                 {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},  16'd0, 5'd2, -11};
    vecs[7]  = '{"mixed_sh1",
                 {8'd9, 8'hF8, 8'd7, 8'hFA, 8'd5, 8'hFC, 8'd3, 8'hFE, 8'd1},
                 {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},  16'd0, 5'd1, 23};
    vecs[8]  = '{"pix_unsigned", {32'd0, 8'hFF, 32'd0}, {K{8'd200}}, 16'd100, 5'd0, -100};
    vecs[9]  = '{"bias_max",     {K{8'd0}},   {K{8'd7}},   16'h7FFF,   5'd0,  127};
    vecs[10] = '{"bias_min_sh8", {K{8'd0}},   {K{8'd7}},   16'h8000,   5'd8,  -128};
    vecs[11] = '{"bias_sh31",    {K{8'd0}},   {K{8'd7}},   16'h7FFF,   5'd31, 0};
    vecs[12] = '{"ones_sh3",     {K{8'd1}},   {K{8'd10}},  16'd0,      5'd3,  11};

    rst        = 1'b1;
    coef_valid = 1'b0;
    coef_data  = '0;
    coef_clear = 1'b0;
    win_valid  = 1'b0;
    window     = '0;
    cfg_bias   = '0;
    cfg_shift  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", int'(coef_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_pixel", int'(out_pixel), 0);
    chk("rst_drop", int'(drop_cnt), 0);

    // Windows before the kernel completes are dropped; a 10th coefficient is ignored
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      coef_valid = 1'b1;
      coef_data  = 8'd1;
      seen |= out_valid;
    end
    @(negedge clk);
    coef_valid = 1'b0;
    win_valid  = 1'b1;
    window     = {K{8'd10}};
    repeat (2) begin
      @(negedge clk);
      seen |= out_valid;
    end
    @(negedge clk);
    win_valid  = 1'b0;
    coef_valid = 1'b1;
    coef_data  = 8'd1;
    @(negedge clk);
    coef_data  = 8'd100;
    @(negedge clk);
    coef_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("early_drop_cnt", int'(drop_cnt), 3);
    chk("early_no_out", int'(seen), 0);
    chk("early_ready", int'(coef_ready), 1);
    run_window({K{8'd10}}, 16'd0, 5'd0, lat, val);
    chk("coef10_ignored_lat", lat, 4);
    chk("coef10_ignored_val", val, 90);

    for (int i = 0; i < 13; i++) begin
      load_kernel(vecs[i].coef);
      chk({vecs[i].name, "_ready"}, int'(coef_ready), 1);
      run_window(vecs[i].pix, vecs[i].bias, vecs[i].shift, lat, val);
      chk({vecs[i].name, "_lat"}, lat, 4);
      chk({vecs[i].name, "_val"}, val, relu(vecs[i].exp_val));
    end

    // 20 back-to-back windows, centre=n with bias=n, result 2n
    load_kernel({32'd0, 8'd1, 32'd0});
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      if (i >= 4 && i < 24) begin
        chk("b2b_valid", int'(out_valid), 1);
        chk("b2b_pixel", int'($signed(out_pixel)), 2 * (i - 3));
      end else begin
        chk("b2b_idle", int'(out_valid), 0);
      end
      if (i < 20) begin
        pv        = {K{8'd255}};
        pv[4]     = 8'(i + 1);
        window    = pv;
        cfg_bias  = 16'(i + 1);
        cfg_shift = 5'd0;
        win_valid = 1'b1;
      end else begin
        win_valid = 1'b0;
      end
    end

    // Clear right after an accepted window: that window still completes
    load_kernel({K{8'd1}});
    drop0 = int'(drop_cnt);
    @(negedge clk);
    window    = {K{8'd10}};
    cfg_bias  = 16'd0;
    cfg_shift = 5'd0;
    win_valid = 1'b1;
    @(negedge clk);
    coef_clear = 1'b1;
    @(negedge clk);
    coef_clear = 1'b0;
    chk("clr_ready", int'(coef_ready), 0);
    @(negedge clk);
    @(negedge clk);
    win_valid = 1'b0;
    chk("clr_inflight_valid", int'(out_valid), 1);
    chk("clr_inflight_pixel", int'($signed(out_pixel)), 90);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("clr_no_more_out", int'(seen), 0);
    chk("clr_drops", int'(drop_cnt) - drop0, 3);
    for (int k = 0; k < K; k++) begin
      @(negedge clk);
      if (k == K - 1) chk("reload_ready_8", int'(coef_ready), 0);
      coef_valid = 1'b1;
      coef_data  = 8'd3;
    end
    @(negedge clk);
    coef_valid = 1'b0;
    chk("reload_ready_9", int'(coef_ready), 1);
    run_window({K{8'd3}}, 16'd0, 5'd0, lat, val);
    chk("reload_val", val, 81);

    // Reset with a window in flight
    @(negedge clk);
    window    = {K{8'd10}};
    win_valid = 1'b1;
    @(negedge clk);
    win_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("midrst_no_out", int'(seen), 0);
    chk("midrst_ready", int'(coef_ready), 0);
    chk("midrst_drop", int'(drop_cnt), 0);

    // Clear beats a same-cycle coefficient write in LOAD
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      coef_valid = 1'b1;
      coef_data  = 8'd50;
    end
    @(negedge clk);
    coef_clear = 1'b1;
    for (int k = 0; k < K; k++) begin
      @(negedge clk);
      if (k == K - 1) chk("clrwin_ready_8", int'(coef_ready), 0);
      coef_clear = 1'b0;
      coef_valid = 1'b1;
      coef_data  = 8'd1;
    end
    @(negedge clk);
    coef_valid = 1'b0;
    chk("clrwin_ready_9", int'(coef_ready), 1);
    run_window({K{8'd10}}, 16'd0, 5'd0, lat, val);
    chk("clrwin_val", val, 90);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
